// File: rtl/tennis_match_if.sv
// tennis_match_if
//   Bundle of the signals between the tennis match sequencer and the
//   button / nL shift-register / ball-tick datapath.
//   master : datapath side, drives button/ball status, reads controls
//   slave  : match sequencer, reads button/ball status, drives controls
//   Inputs to the sequencer : toss, hitPulse, moveBall, ballInPlay, ballLoc
//   Outputs of the sequencer: serveReq, serverRight, speedReload, scoreL,
//                             scoreR, rallyCount, matchOver, state
interface tennis_match_if #(
  parameter int SPEED_BITS = 25
);
  logic                  toss;
  logic                  hitPulse;
  logic                  moveBall;
  logic                  ballInPlay;
  logic [2:0]            ballLoc;
  logic                  serveReq;
  logic                  serverRight;
  logic [SPEED_BITS-1:0] speedReload;
  logic [3:0]            scoreL;
  logic [3:0]            scoreR;
  logic [7:0]            rallyCount;
  logic                  matchOver;
  logic [2:0]            state;

  modport master (
    output toss, hitPulse, moveBall, ballInPlay, ballLoc,
    input  serveReq, serverRight, speedReload, scoreL, scoreR,
           rallyCount, matchOver, state
  );

  modport slave (
    input  toss, hitPulse, moveBall, ballInPlay, ballLoc,
    output serveReq, serverRight, speedReload, scoreL, scoreR,
           rallyCount, matchOver, state
  );
endinterface

// File: rtl/tennis_match_ctrl.sv
// tennis_match_ctrl
//   Match sequencer for the tennis game. Gates serves, sets the ball-tick
//   reload value (speeds up on every return), detects the ball leaving the
//   court, awards points, keeps score and declares the match winner.
//   Ports:
//     CLK100MHZ  system clock
//     nReset     asynchronous active-low reset
//     bus        tennis_match_if.slave (button/ball status in, controls out)
//
//   state | meaning
//   IDLE  | waiting for a toss to start a serve
//   SERVE | serve allowed, waiting for the ball to enter play
//   RALLY | ball in play, counting returns and speeding up
//   POINT | point awarded, short pause before the next serve
//   OVER  | match won, scores frozen until the next toss
module tennis_match_ctrl #(
  parameter int          SPEED_BITS  = 25,
  parameter int unsigned SPEED_INIT  = 33554431,
  parameter int unsigned SPEED_STEP  = 500000,
  parameter int unsigned SPEED_MIN   = 4000000,
  parameter int unsigned WIN_POINTS  = 7,
  parameter int unsigned POINT_TICKS = 3,
  parameter int unsigned SERVE_TICKS = 4
) (
  input  logic          CLK100MHZ,
  input  logic          nReset,
  tennis_match_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    RALLY = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } stateT;

  localparam int unsigned MAX_TICKS = (POINT_TICKS > SERVE_TICKS) ? POINT_TICKS : SERVE_TICKS;
  localparam int TICK_BITS = $clog2(MAX_TICKS + 1);

  localparam logic [SPEED_BITS-1:0] INIT_V = SPEED_BITS'(SPEED_INIT);
  localparam logic [SPEED_BITS-1:0] MIN_V  = SPEED_BITS'(SPEED_MIN);
  localparam logic [SPEED_BITS:0]   STEP_W = (SPEED_BITS+1)'(SPEED_STEP);
  localparam logic [SPEED_BITS:0]   MIN_W  = (SPEED_BITS+1)'(SPEED_MIN);
  localparam logic [TICK_BITS-1:0]  POINT_LAST = TICK_BITS'(POINT_TICKS - 1);
  localparam logic [TICK_BITS-1:0]  SERVE_LAST = TICK_BITS'(SERVE_TICKS - 1);
  localparam logic [3:0]            WIN_V = 4'(WIN_POINTS);

  stateT                 stateQ, stateD;
  logic                  tossPrev, inPlayPrev;
  logic [2:0]            lastLocQ, lastLocD;
  logic [TICK_BITS-1:0]  tickQ, tickD;
  logic                  serveReqQ, serveReqD;
  logic                  serverRightQ, serverRightD;
  logic [SPEED_BITS-1:0] speedQ, speedD;
  logic [3:0]            scoreLQ, scoreLD, scoreRQ, scoreRD;
  logic [7:0]            rallyQ, rallyD;
  logic                  matchOverQ, matchOverD;

  logic                  tossRise, inPlayRise, inPlayFall;
  logic [SPEED_BITS:0]   speedDiff;
  logic [SPEED_BITS-1:0] speedFaster;

  assign tossRise   = bus.toss & ~tossPrev;
  assign inPlayRise = bus.ballInPlay & ~inPlayPrev;
  assign inPlayFall = ~bus.ballInPlay & inPlayPrev;

  // One extra bit so a subtraction below zero shows up as a set MSB
  // instead of wrapping to a huge (slow) reload value.
  assign speedDiff   = {1'b0, speedQ} - STEP_W;
  assign speedFaster = (speedDiff[SPEED_BITS] || (speedDiff < MIN_W)) ?
                       MIN_V : speedDiff[SPEED_BITS-1:0];

  always_ff @(posedge CLK100MHZ or negedge nReset) begin
    if (!nReset) begin
      stateQ       <= IDLE;
      tossPrev     <= 1'b0;
      inPlayPrev   <= 1'b0;
      lastLocQ     <= 3'd7;
      tickQ        <= '0;
      serveReqQ    <= 1'b0;
      serverRightQ <= 1'b1;
      speedQ       <= INIT_V;
      scoreLQ      <= 4'd0;
      scoreRQ      <= 4'd0;
      rallyQ       <= 8'd0;
      matchOverQ   <= 1'b0;
    end else begin
      stateQ       <= stateD;
      tossPrev     <= bus.toss;
      inPlayPrev   <= bus.ballInPlay;
      lastLocQ     <= lastLocD;
      tickQ        <= tickD;
      serveReqQ    <= serveReqD;
      serverRightQ <= serverRightD;
      speedQ       <= speedD;
      scoreLQ      <= scoreLD;
      scoreRQ      <= scoreRD;
      rallyQ       <= rallyD;
      matchOverQ   <= matchOverD;
    end
  end

  always_comb begin
    stateD       = stateQ;
    lastLocD     = lastLocQ;
    tickD        = tickQ;
    serverRightD = serverRightQ;
    speedD       = speedQ;
    scoreLD      = scoreLQ;
    scoreRD      = scoreRQ;
    rallyD       = rallyQ;

    case (stateQ)
      IDLE: begin
        if (tossRise) begin
          stateD = SERVE;
          rallyD = 8'd0;
          tickD  = '0;
        end
      end

      SERVE: begin
        if (inPlayRise) begin
          stateD = RALLY;
        end else if (bus.moveBall) begin
          if (tickQ == SERVE_LAST) begin
            stateD = IDLE;
          end else begin
            tickD = tickQ + 1'b1;
          end
        end
      end

      RALLY: begin
        if (bus.ballInPlay) begin
          lastLocD = bus.ballLoc;
        end
        // Ball leaving the court wins over a simultaneous swing.
        if (inPlayFall) begin
          if (lastLocQ <= 3'd3) begin
            scoreRD = scoreRQ + 4'd1;
          end else begin
            scoreLD = scoreLQ + 4'd1;
          end
          stateD = POINT;
          tickD  = '0;
        end else if (bus.hitPulse) begin
          if (rallyQ != 8'hFF) begin
            rallyD = rallyQ + 8'd1;
          end
          speedD = speedFaster;
        end
      end

      POINT: begin
        if (bus.moveBall) begin
          if (tickQ == POINT_LAST) begin
            if ((scoreLQ == WIN_V) || (scoreRQ == WIN_V)) begin
              stateD = OVER;
            end else begin
              stateD       = IDLE;
              speedD       = INIT_V;
              serverRightD = ~serverRightQ;
            end
          end else begin
            tickD = tickQ + 1'b1;
          end
        end
      end

      OVER: begin
        if (tossRise) begin
          stateD       = IDLE;
          scoreLD      = 4'd0;
          scoreRD      = 4'd0;
          rallyD       = 8'd0;
          speedD       = INIT_V;
          serverRightD = 1'b1;
        end
      end

      default: stateD = IDLE;
    endcase

    serveReqD  = (stateD == SERVE);
    matchOverD = (stateD == OVER);
  end

  assign bus.state       = stateQ;
  assign bus.serveReq    = serveReqQ;
  assign bus.serverRight = serverRightQ;
  assign bus.speedReload = speedQ;
  assign bus.scoreL      = scoreLQ;
  assign bus.scoreR      = scoreRQ;
  assign bus.rallyCount  = rallyQ;
  assign bus.matchOver   = matchOverQ;

endmodule

// File: tb/tb_tennis_match_ctrl.sv
// tb_tennis_match_ctrl
//   Directed bench for tennis_match_ctrl with default parameters: serve,
//   speed ramp and floor, scoring both sides, serve timeout, held toss,
//   hit coincident with ball out, match end and asynchronous reset.
module tb_tennis_match_ctrl;
  localparam longint INIT = 33554431;
  localparam longint STEP = 500000;
  localparam longint SMIN = 4000000;

  logic CLK100MHZ = 1'b0;
  logic nReset    = 1'b0;
  int   total     = 0;
  int   bad       = 0;
  longint expSpeed;

  tennis_match_if #(.SPEED_BITS(25)) bus ();

  tennis_match_ctrl dut (
    .CLK100MHZ (CLK100MHZ),
    .nReset    (nReset),
    .bus       (bus.slave)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  task automatic tick();
    @(posedge CLK100MHZ);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic serve();
    bus.toss = 1'b1;
    tick();
    bus.toss = 1'b0;
    bus.ballInPlay = 1'b1;
    tick();
  endtask

  task automatic playPoint(input logic [2:0] loc);
    bus.ballLoc = loc;
    tick();
    bus.ballInPlay = 1'b0;
    tick();
    repeat (3) begin
      bus.moveBall = 1'b1;
      tick();
    end
    bus.moveBall = 1'b0;
  endtask

  initial begin
    bus.toss       = 1'b0;
    bus.hitPulse   = 1'b0;
    bus.moveBall   = 1'b0;
    bus.ballInPlay = 1'b0;
    bus.ballLoc    = 3'd7;

    // Reset values
    tick();
    tick();
    check("rst_state", 32'(bus.state), 0);
    check("rst_serveReq", 32'(bus.serveReq), 0);
    check("rst_serverRight", 32'(bus.serverRight), 1);
    check("rst_speed", 32'(bus.speedReload), 32'(INIT));
    check("rst_scores", {bus.scoreL, bus.scoreR}, 0);
    check("rst_rally", 32'(bus.rallyCount), 0);
    check("rst_matchOver", 32'(bus.matchOver), 0);
    nReset = 1'b1;
    tick();

    // Serve
    bus.toss = 1'b1;
    tick();
    check("serve_state", 32'(bus.state), 1);
    check("serve_req", 32'(bus.serveReq), 1);
    bus.toss = 1'b0;
    bus.ballInPlay = 1'b1;
    tick();
    check("rally_state", 32'(bus.state), 2);
    check("rally_serveReq", 32'(bus.serveReq), 0);

    // Speed ramp down to the floor
    bus.hitPulse = 1'b1;
    for (int k = 1; k <= 61; k++) begin
      tick();
      expSpeed = INIT - longint'(k) * STEP;
      if (expSpeed < SMIN) expSpeed = SMIN;
      if (k == 1 || k == 59 || k == 60 || k == 61)
        check($sformatf("ramp_speed_%0d", k), 32'(bus.speedReload), 32'(expSpeed));
      if (k == 60) check("ramp_rally_60", 32'(bus.rallyCount), 60);
    end
    bus.hitPulse = 1'b0;
    check("ramp_rally_61", 32'(bus.rallyCount), 61);

    // Ball out on the left side -> right player scores
    bus.ballLoc = 3'd0;
    tick();
    bus.ballInPlay = 1'b0;
    tick();
    check("ptR_state", 32'(bus.state), 3);
    check("ptR_scoreR", 32'(bus.scoreR), 1);
    check("ptR_scoreL", 32'(bus.scoreL), 0);
    bus.toss = 1'b1;
    tick();
    bus.toss = 1'b0;
    check("point_toss_ignored", 32'(bus.state), 3);
    bus.moveBall = 1'b1;
    tick();
    tick();
    check("point_hold", 32'(bus.state), 3);
    tick();
    bus.moveBall = 1'b0;
    check("point_done_state", 32'(bus.state), 0);
    check("point_done_server", 32'(bus.serverRight), 0);
    check("point_done_speed", 32'(bus.speedReload), 32'(INIT));

    // Serve abandoned after 4 ticks, held toss does not retrigger
    bus.toss = 1'b1;
    tick();
    check("held_serve_state", 32'(bus.state), 1);
    check("held_rally_clear", 32'(bus.rallyCount), 0);
    bus.moveBall = 1'b1;
    repeat (3) tick();
    check("serve_3ticks", 32'(bus.state), 1);
    tick();
    bus.moveBall = 1'b0;
    check("serve_timeout_state", 32'(bus.state), 0);
    check("serve_timeout_req", 32'(bus.serveReq), 0);
    check("serve_timeout_scores", {bus.scoreL, bus.scoreR}, 32'h01);
    repeat (3) tick();
    check("held_toss_no_retrigger", 32'(bus.state), 0);
    bus.toss = 1'b0;
    tick();

    // Hit coincident with ball out on the right -> left scores, hit ignored
    serve();
    check("serve2_state", 32'(bus.state), 2);
    bus.hitPulse = 1'b1;
    tick();
    bus.hitPulse = 1'b0;
    check("serve2_rally", 32'(bus.rallyCount), 1);
    bus.ballLoc = 3'd7;
    tick();
    bus.ballInPlay = 1'b0;
    bus.hitPulse = 1'b1;
    tick();
    bus.hitPulse = 1'b0;
    check("coinc_state", 32'(bus.state), 3);
    check("coinc_scoreL", 32'(bus.scoreL), 1);
    check("coinc_rally", 32'(bus.rallyCount), 1);
    check("coinc_speed", 32'(bus.speedReload), 32'(INIT - STEP));
    bus.moveBall = 1'b1;
    repeat (3) tick();
    bus.moveBall = 1'b0;
    check("coinc_done_state", 32'(bus.state), 0);
    check("coinc_done_server", 32'(bus.serverRight), 1);

    // Left player wins the match
    repeat (6) begin
      serve();
      playPoint(3'd7);
    end
    check("over_state", 32'(bus.state), 4);
    check("over_matchOver", 32'(bus.matchOver), 1);
    check("over_scores", {bus.scoreL, bus.scoreR}, 32'h71);
    bus.toss = 1'b1;
    tick();
    bus.toss = 1'b0;
    check("restart_state", 32'(bus.state), 0);
    check("restart_scores", {bus.scoreL, bus.scoreR}, 0);
    check("restart_matchOver", 32'(bus.matchOver), 0);
    check("restart_server", 32'(bus.serverRight), 1);
    check("restart_speed", 32'(bus.speedReload), 32'(INIT));
    tick();

    // Asynchronous reset in the middle of a rally
    serve();
    playPoint(3'd0);
    check("pre_reset_scoreR", 32'(bus.scoreR), 1);
    serve();
    bus.hitPulse = 1'b1;
    tick();
    tick();
    bus.hitPulse = 1'b0;
    check("pre_reset_state", 32'(bus.state), 2);
    nReset = 1'b0;
    #2;
    check("async_state", 32'(bus.state), 0);
    check("async_scores", {bus.scoreL, bus.scoreR}, 0);
    check("async_speed", 32'(bus.speedReload), 32'(INIT));
    check("async_rally", 32'(bus.rallyCount), 0);
    check("async_serveReq", 32'(bus.serveReq), 0);
    tick();
    nReset = 1'b1;
    bus.ballInPlay = 1'b0;
    tick();
    check("post_reset_state", 32'(bus.state), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
